// File: rtl/forward_pass.sv
// forward_pass: forward inference of the 2-2-1 XOR network (8.8 signed fixed point).
// Five-state FSM: IDLE -> HID -> RELU -> OUT -> SIG -> IDLE.
// Optional feature macro: FWD_SATURATE_EN clamps pre-activations to 16 bits
// instead of wrapping.
//
// state | meaning
// ------+---------------------------------------------------------------
// IDLE  | waiting for start; operands latched when start is seen
// HID   | hidden pre-activations z1, z2
// RELU  | h1, h2 = ReLU(z1), ReLU(z2)
// OUT   | output pre-activation z3
// SIG   | y = piecewise-linear sigmoid(z3), valid pulses next cycle
module forward_pass (
  input  logic               clk,
  input  logic               rst,
  input  logic               start,
  input  logic signed [15:0] x1,
  input  logic signed [15:0] x2,
  input  logic signed [15:0] w11,
  input  logic signed [15:0] w12,
  input  logic signed [15:0] w21,
  input  logic signed [15:0] w22,
  input  logic signed [15:0] w31,
  input  logic signed [15:0] w32,
  input  logic signed [15:0] b1,
  input  logic signed [15:0] b2,
  input  logic signed [15:0] b3,
  output logic signed [15:0] h1,
  output logic signed [15:0] h2,
  output logic signed [15:0] y,
  output logic               busy,
  output logic               valid
);

  typedef enum logic [2:0] {IDLE, HID, RELU, OUT, SIG} state_t;

  state_t state;
  logic signed [15:0] x1_q, x2_q, w11_q, w12_q, w21_q, w22_q, w31_q, w32_q;
  logic signed [15:0] b1_q, b2_q, b3_q;
  logic signed [15:0] z1, z2, z3;

  // Rounded 8.8 product at 32 bits: (a*b + 0.5 LSB) >>> 8.
  function automatic logic signed [31:0] rmul(input logic signed [15:0] a,
                                              input logic signed [15:0] b);
    logic signed [31:0] p;
    p = 32'(a) * 32'(b);
    return (p + 32'sd128) >>> 8;
  endfunction

  // Reduce a 32-bit pre-activation to 16 bits.
  function automatic logic signed [15:0] reduce(input logic signed [31:0] z);
`ifdef FWD_SATURATE_EN
    if (z > 32'sd32767) return 16'sh7fff;
    else if (z < -32'sd32768) return 16'sh8000;
    else return z[15:0];
`else
    return z[15:0];
`endif
  endfunction

  function automatic logic signed [15:0] relu(input logic signed [15:0] z);
    return (z > 16'sd0) ? z : 16'sd0;
  endfunction

  // Piecewise-linear sigmoid, symmetric around 0.5 (128).
  function automatic logic signed [15:0] sigmoid(input logic signed [15:0] z);
    logic [15:0] a;
    logic [15:0] f;
    if (z == 16'sh8000) a = 16'd32767;
    else if (z < 16'sd0) a = 16'(-z);
    else a = 16'(z);
    if (a >= 16'd1280) f = 16'd256;
    else if (a >= 16'd608) f = (a >> 5) + 16'd216;
    else if (a >= 16'd256) f = (a >> 3) + 16'd160;
    else f = (a >> 2) + 16'd128;
    return (z >= 16'sd0) ? $signed(f) : $signed(16'd256 - f);
  endfunction

  // Sequencer, operand capture, datapath registers and registered outputs.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= IDLE;
      x1_q <= '0; x2_q <= '0;
      w11_q <= '0; w12_q <= '0; w21_q <= '0; w22_q <= '0;
      w31_q <= '0; w32_q <= '0;
      b1_q <= '0; b2_q <= '0; b3_q <= '0;
      z1 <= '0; z2 <= '0; z3 <= '0;
      h1 <= '0; h2 <= '0; y <= '0;
      busy <= 1'b0;
      valid <= 1'b0;
    end else begin
      valid <= 1'b0;
      case (state)
        IDLE: begin
          if (start) begin
            x1_q <= x1; x2_q <= x2;
            w11_q <= w11; w12_q <= w12; w21_q <= w21; w22_q <= w22;
            w31_q <= w31; w32_q <= w32;
            b1_q <= b1; b2_q <= b2; b3_q <= b3;
            busy <= 1'b1;
            state <= HID;
          end
        end
        HID: begin
          z1 <= reduce(rmul(w11_q, x1_q) + rmul(w12_q, x2_q) + 32'(b1_q));
          z2 <= reduce(rmul(w21_q, x1_q) + rmul(w22_q, x2_q) + 32'(b2_q));
          state <= RELU;
        end
        RELU: begin
          h1 <= relu(z1);
          h2 <= relu(z2);
          state <= OUT;
        end
        OUT: begin
          z3 <= reduce(rmul(w31_q, h1) + rmul(w32_q, h2) + 32'(b3_q));
          state <= SIG;
        end
        SIG: begin
          y <= sigmoid(z3);
          valid <= 1'b1;
          busy <= 1'b0;
          state <= IDLE;
        end
        default: begin
          busy <= 1'b0;
          state <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_forward_pass.sv
// Directed testbench for forward_pass.
module tb_forward_pass;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic start = 1'b0;
  logic signed [15:0] x1, x2, w11, w12, w21, w22, w31, w32, b1, b2, b3;
  logic signed [15:0] h1, h2, y;
  logic busy, valid;

  int tests = 0;
  int fails = 0;

  always #5 clk = ~clk;

  forward_pass dut (
    .clk(clk), .rst(rst), .start(start),
    .x1(x1), .x2(x2),
    .w11(w11), .w12(w12), .w21(w21), .w22(w22),
    .w31(w31), .w32(w32),
    .b1(b1), .b2(b2), .b3(b3),
    .h1(h1), .h2(h2), .y(y),
    .busy(busy), .valid(valid)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic set_net(input int ix1, input int ix2,
                         input int i11, input int i12, input int i21, input int i22,
                         input int i31, input int i32,
                         input int ib1, input int ib2, input int ib3);
    x1 = 16'(ix1); x2 = 16'(ix2);
    w11 = 16'(i11); w12 = 16'(i12); w21 = 16'(i21); w22 = 16'(i22);
    w31 = 16'(i31); w32 = 16'(i32);
    b1 = 16'(ib1); b2 = 16'(ib2); b3 = 16'(ib3);
  endtask

  // Pulse start for one edge and count edges until valid is seen (bounded).
  task automatic run_pass(output int lat);
    start = 1'b1;
    tick();
    start = 1'b0;
    lat = 1;
    while (!valid && lat < 20) begin
      tick();
      lat++;
    end
  endtask

  task automatic test_reset();
    set_net(256, 0, 256, 256, 256, 256, 256, -512, 0, -256, 0);
    rst = 1'b1;
    tick();
    tests++;
    if (h1 !== 16'sd0 || h2 !== 16'sd0 || y !== 16'sd0 || busy !== 1'b0 || valid !== 1'b0) begin
      fails++;
      $display("FAIL reset_state: h1=%0d h2=%0d y=%0d busy=%b valid=%b, want all 0",
               h1, h2, y, busy, valid);
    end
    rst = 1'b0;
    tick();
  endtask

  task automatic test_nominal();
    int lat;
    set_net(256, 0, 256, 256, 256, 256, 256, -512, 0, -256, 0);
    start = 1'b1;
    tick();
    start = 1'b0;
    tests++;
    if (busy !== 1'b1) begin
      fails++;
      $display("FAIL nominal_busy: busy=%b want 1", busy);
    end
    // Operands already captured; scramble the inputs while busy.
    set_net(-1000, 777, -5, 9, 300, -300, 12, 34, 500, 500, -700);
    lat = 1;
    while (!valid && lat < 20) begin
      tick();
      lat++;
    end
    tests++;
    if (lat !== 5) begin
      fails++;
      $display("FAIL nominal_latency: %0d clocks, want 5", lat);
    end
    tests++;
    if (h1 !== 16'sd256 || h2 !== 16'sd0 || y !== 16'sd192) begin
      fails++;
      $display("FAIL nominal_values: h1=%0d h2=%0d y=%0d, want 256 0 192", h1, h2, y);
    end
    tests++;
    if (busy !== 1'b0) begin
      fails++;
      $display("FAIL nominal_busy_drop: busy=%b with valid, want 0", busy);
    end
    tick();
    tests++;
    if (valid !== 1'b0 || h1 !== 16'sd256 || y !== 16'sd192) begin
      fails++;
      $display("FAIL nominal_width_hold: valid=%b h1=%0d y=%0d, want 0 256 192", valid, h1, y);
    end
  endtask

  task automatic test_relu_clamp();
    int lat;
    set_net(256, 256, -256, 0, 0, 0, 256, 0, 0, 0, 0);
    run_pass(lat);
    tests++;
    if (h1 !== 16'sd0 || h2 !== 16'sd0 || y !== 16'sd128) begin
      fails++;
      $display("FAIL relu_clamp: h1=%0d h2=%0d y=%0d, want 0 0 128", h1, h2, y);
    end
  endtask

  task automatic test_sigmoid();
    int lat;
    int w3 [6] = '{1536, -1536, 608, 100, -256, 2000};
    int exp_y [6] = '{256, 0, 235, 153, 64, 256};
    for (int i = 0; i < 6; i++) begin
      set_net(256, 0, 256, 0, 0, 0, w3[i], 0, 0, 0, 0);
      run_pass(lat);
      tests++;
      if (lat !== 5 || h1 !== 16'sd256 || y !== 16'(exp_y[i])) begin
        fails++;
        $display("FAIL sigmoid_%0d: lat=%0d h1=%0d y=%0d, want 5 256 %0d",
                 w3[i], lat, h1, y, exp_y[i]);
      end
    end
  endtask

  task automatic test_overflow();
    int lat;
    logic signed [15:0] exp_h1;
`ifdef FWD_SATURATE_EN
    exp_h1 = 16'sd32767;
`else
    exp_h1 = 16'sd0;
`endif
    set_net(32767, 32767, 32767, 32767, 0, 0, 0, 0, 0, 0, 0);
    run_pass(lat);
    tests++;
    if (h1 !== exp_h1) begin
      fails++;
      $display("FAIL overflow_h1: h1=%0d want %0d", h1, exp_h1);
    end
  endtask

  task automatic test_back_to_back();
    int nvalid;
    int last;
    int bad_gap;
    set_net(256, 0, 256, 256, 256, 256, 256, -512, 0, -256, 0);
    nvalid = 0;
    last = -1;
    bad_gap = 0;
    start = 1'b1;
    for (int c = 0; c < 25; c++) begin
      tick();
      if (valid) begin
        if (last >= 0 && c - last != 5) bad_gap++;
        last = c;
        nvalid++;
      end
    end
    start = 1'b0;
    tests++;
    if (nvalid !== 5 || bad_gap !== 0) begin
      fails++;
      $display("FAIL back_to_back: %0d valids, %0d bad gaps, want 5 and 0", nvalid, bad_gap);
    end
    while (busy) tick();
    tick();
  endtask

  task automatic test_start_while_busy();
    int nvalid;
    set_net(256, 0, 256, 0, 0, 0, 256, 0, 0, 0, 0);
    nvalid = 0;
    for (int c = 0; c < 14; c++) begin
      start = (c == 0 || c == 2 || c == 3) ? 1'b1 : 1'b0;
      tick();
      if (valid) nvalid++;
    end
    start = 1'b0;
    tests++;
    if (nvalid !== 1) begin
      fails++;
      $display("FAIL start_while_busy: %0d valids, want 1", nvalid);
    end
  endtask

  task automatic test_reset_mid_pass();
    int nvalid;
    int lat;
    set_net(256, 0, 256, 256, 256, 256, 256, -512, 0, -256, 0);
    start = 1'b1;
    tick();
    start = 1'b0;
    tick();
    tick();
    rst = 1'b1;
    #1;
    tests++;
    if (h1 !== 16'sd0 || h2 !== 16'sd0 || y !== 16'sd0 || busy !== 1'b0 || valid !== 1'b0) begin
      fails++;
      $display("FAIL reset_mid: h1=%0d h2=%0d y=%0d busy=%b valid=%b, want all 0",
               h1, h2, y, busy, valid);
    end
    tick();
    rst = 1'b0;
    nvalid = 0;
    for (int c = 0; c < 8; c++) begin
      tick();
      if (valid || busy) nvalid++;
    end
    tests++;
    if (nvalid !== 0) begin
      fails++;
      $display("FAIL reset_mid_quiet: %0d cycles with valid/busy, want 0", nvalid);
    end
    run_pass(lat);
    tests++;
    if (lat !== 5 || h1 !== 16'sd256 || y !== 16'sd192) begin
      fails++;
      $display("FAIL reset_mid_restart: lat=%0d h1=%0d y=%0d, want 5 256 192", lat, h1, y);
    end
  endtask

  initial begin
    test_reset();
    test_nominal();
    test_relu_clamp();
    test_sigmoid();
    test_overflow();
    test_back_to_back();
    test_start_while_busy();
    test_reset_mid_pass();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
